// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow controller for the 9-bit core.
// It owns the PC, the start/done handshake, the jump-target LUT, the stored
// ALU flags and a saturating count of executed instructions.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           run request, honoured only in IDLE or DONE
//   halt            current instruction is the program end
//   pc_jmp_en       take a jump this cycle
//   lut_ptr         jump-target LUT index
//   flags_we        capture flags_in, in any state
//   flags_in        {cflag,nflag,zflag} from the ALU
//   lut_wr_en       LUT write strobe, in any state
//   lut_wr_addr     LUT write index
//   lut_wr_data     LUT write target address
//   pc              instruction memory address
//   fetch_en        the instruction at pc executes this cycle
//   flags_q         stored flags for the decoder
//   done            program finished
//   runaway         sticky: PC ran off the end of memory
//   cycle_cnt       executed-instruction count, saturating
module pc_sequencer #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16,
  parameter int CNT_W     = 16,
  localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             pc_jmp_en,
  input  logic [IDX_W-1:0] lut_ptr,
  input  logic             flags_we,
  input  logic [2:0]       flags_in,
  input  logic             lut_wr_en,
  input  logic [IDX_W-1:0] lut_wr_addr,
  input  logic [PC_W-1:0]  lut_wr_data,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic [2:0]       flags_q,
  output logic             done,
  output logic             runaway,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_MAX  = '1;
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          state;
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic [PC_W-1:0] jmp_target;

  // The read uses the pre-edge array contents, so a write to the same
  // index in the same cycle is not visible until the following cycle.
  assign jmp_target = lut[lut_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_wr_en) begin
      lut[lut_wr_addr] <= lut_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 3'b000;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  // Control FSM; fetch_en and done are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      fetch_en  <= 1'b0;
      done      <= 1'b0;
      runaway   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          if (start) begin
            state     <= RUN;
            pc        <= '0;
            fetch_en  <= 1'b1;
            done      <= 1'b0;
            runaway   <= 1'b0;
            cycle_cnt <= '0;
          end
        end
        RUN: begin
          if (cycle_cnt != CNT_MAX) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
          end
          // halt outranks a same-cycle jump; the end-of-memory stop
          // only applies when no jump redirects the PC.
          if (halt) begin
            state    <= FIN;
            fetch_en <= 1'b0;
            done     <= 1'b1;
          end else if (pc_jmp_en) begin
            pc <= jmp_target;
          end else if (pc == PC_MAX) begin
            state    <= FIN;
            fetch_en <= 1'b0;
            done     <= 1'b1;
            runaway  <= 1'b1;
          end else begin
            pc <= pc + PC_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          fetch_en <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Linear stimulus in one initial block, immediate assertions at each check.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic        pc_jmp_en;
  logic [3:0]  lut_ptr;
  logic        flags_we;
  logic [2:0]  flags_in;
  logic        lut_wr_en;
  logic [3:0]  lut_wr_addr;
  logic [9:0]  lut_wr_data;
  logic [9:0]  pc;
  logic        fetch_en;
  logic [2:0]  flags_q;
  logic        done;
  logic        runaway;
  logic [15:0] cycle_cnt;

  int tests = 0;
  int fails = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .pc_jmp_en   (pc_jmp_en),
    .lut_ptr     (lut_ptr),
    .flags_we    (flags_we),
    .flags_in    (flags_in),
    .lut_wr_en   (lut_wr_en),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .flags_q     (flags_q),
    .done        (done),
    .runaway     (runaway),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [9:0] d);
    lut_wr_en   = 1'b1;
    lut_wr_addr = a;
    lut_wr_data = d;
    tick();
    lut_wr_en   = 1'b0;
  endtask

  task automatic jump(input logic [3:0] p);
    pc_jmp_en = 1'b1;
    lut_ptr   = p;
    tick();
    pc_jmp_en = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; halt = 1'b0; pc_jmp_en = 1'b0;
    lut_ptr = '0; flags_we = 1'b0; flags_in = '0; lut_wr_en = 1'b0;
    lut_wr_addr = '0; lut_wr_data = '0;
    tick(); tick();

    chk("rst_pc", pc, 0);
    chk("rst_fetch", fetch_en, 0);
    chk("rst_done", done, 0);
    chk("rst_runaway", runaway, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_flags", flags_q, 0);

    reset = 1'b0;
    tick();
    chk("idle_fetch", fetch_en, 0);

    // flags captured while idle
    flags_we = 1'b1; flags_in = 3'b110;
    tick();
    flags_we = 1'b0;
    chk("idle_flags", flags_q, 3'b110);

    // 1) straight-line run
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("line_pc%0d", i), pc, i);
      chk($sformatf("line_fe%0d", i), fetch_en, 1);
      tick();
    end
    chk("line_cnt", cycle_cnt, 5);
    chk("line_pc5", pc, 5);

    // 2) jump via LUT, same-cycle write returns old entry
    lut_write(4'd3, 10'h040);
    chk("pre_jmp_pc6", pc, 6);
    tick();
    chk("pre_jmp_pc7", pc, 7);
    lut_wr_en = 1'b1; lut_wr_addr = 4'd3; lut_wr_data = 10'h155;
    jump(4'd3);
    lut_wr_en = 1'b0;
    chk("jmp_old_entry", pc, 10'h040);
    tick();
    chk("jmp_seq", pc, 10'h041);
    jump(4'd3);
    chk("jmp_new_entry", pc, 10'h155);

    // 3) halt beats same-cycle jump
    lut_write(4'd5, 10'd9);
    jump(4'd5);
    chk("at_pc9", pc, 9);
    halt = 1'b1; pc_jmp_en = 1'b1; lut_ptr = 4'd3;
    tick();
    halt = 1'b0; pc_jmp_en = 1'b0;
    chk("halt_done", done, 1);
    chk("halt_pc", pc, 9);
    chk("halt_fetch", fetch_en, 0);
    pc_jmp_en = 1'b1;
    tick(); tick();
    pc_jmp_en = 1'b0;
    chk("done_hold_pc", pc, 9);
    chk("done_hold_cnt", cycle_cnt, 16'd13);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_pc", pc, 0);
    chk("restart_done", done, 0);
    chk("restart_cnt", cycle_cnt, 0);

    // 4) run off end of memory
    lut_write(4'd6, 10'h3FE);
    jump(4'd6);
    chk("edge_pc3fe", pc, 10'h3FE);
    tick();
    chk("edge_pc3ff", pc, 10'h3FF);
    chk("edge_run_done", done, 0);
    tick();
    chk("runaway_set", runaway, 1);
    chk("runaway_done", done, 1);
    chk("runaway_pc", pc, 10'h3FF);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("runaway_clr", runaway, 0);
    chk("runaway_pc0", pc, 0);

    // 5) flags capture and counter saturation
    flags_we = 1'b1; flags_in = 3'b001;
    tick();
    flags_we = 1'b0;
    chk("flags_cap", flags_q, 3'b001);
    pc_jmp_en = 1'b1; lut_ptr = 4'd0;
    n = 0;
    while (cycle_cnt != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    chk("sat_reached", cycle_cnt, 16'hFFFF);
    tick(); tick(); tick();
    pc_jmp_en = 1'b0;
    chk("sat_hold", cycle_cnt, 16'hFFFF);
    chk("loop_pc", pc, 0);

    // 6) start ignored in RUN, then reset mid-run
    lut_write(4'd7, 10'h012);
    jump(4'd7);
    chk("at_pc12", pc, 10'h012);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored", pc, 10'h013);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_fetch", fetch_en, 0);
    chk("arst_done", done, 0);
    chk("arst_flags", flags_q, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_rst_pc1", pc, 1);
    jump(4'd7);
    chk("lut_cleared", pc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
